// File: rtl/cam_power_seq.sv
// cam_power_seq: camera sensor power sequencer.
//   Power-up:   enable supply (cam_pwnd), release sensor reset (cam_rst_n), grant SCCB init.
//   Power-down: revoke init grant, wait for SCCB idle, assert reset, drop supply, let it settle.
//   A power-down request during the power-up ramp aborts straight to the reset-hold phase.
// Optional feature macro: CAM_PD_TIMEOUT_EN bounds the SCCB drain wait and adds pd_timeout.
// Ports:
//   clk        in   24MHz sensor clock
//   rst_n      in   async active-low reset
//   pu_req     in   power-up request pulse
//   pd_req     in   power-down request pulse
//   sccb_busy  in   SCCB master busy, synchronous to clk
//   cam_pwnd   out  1 = sensor supply enabled
//   cam_rst_n  out  sensor reset, 0 = reset
//   initial_en out  SCCB initialisation grant
//   cam_on     out  1 = fully powered
//   pd_done    out  1-cycle pulse when power-down completes
//   pd_timeout out  sticky drain-timeout flag (CAM_PD_TIMEOUT_EN only)
module cam_power_seq #(
    parameter logic [19:0] T_PWR      = 20'h04000,
    parameter logic [19:0] T_RST      = 20'h0ffff,
    parameter logic [19:0] T_INI      = 20'hfffff,
    parameter logic [19:0] T_RST_HOLD = 20'h00100,
    parameter logic [19:0] T_PWD_HOLD = 20'h01000,
    parameter logic [19:0] T_DRAIN    = 20'h0ffff
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pu_req,
    input  logic pd_req,
    input  logic sccb_busy,
    output logic cam_pwnd,
    output logic cam_rst_n,
    output logic initial_en,
    output logic cam_on,
    output logic pd_done
`ifdef CAM_PD_TIMEOUT_EN
    ,
    output logic pd_timeout
`endif
);

    typedef enum logic [2:0] {
        StOff,
        StPwrWait,
        StRstWait,
        StIniWait,
        StOn,
        StDrain,
        StRstHold,
        StPwdHold
    } state_t;

    state_t      r_state;
    state_t      w_state_d;
    logic [19:0] r_cnt;
    logic [19:0] w_cnt_d;
    logic        w_pd_done_d;
`ifdef CAM_PD_TIMEOUT_EN
    logic        w_set_timeout;
    logic        w_clr_timeout;
    logic        r_pd_timeout;
`endif

    always_comb begin
        w_state_d   = r_state;
        w_pd_done_d = 1'b0;
`ifdef CAM_PD_TIMEOUT_EN
        w_set_timeout = 1'b0;
        w_clr_timeout = 1'b0;
`endif
        unique case (r_state)
            StOff: begin
                if (pu_req) begin
                    w_state_d = StPwrWait;
`ifdef CAM_PD_TIMEOUT_EN
                    w_clr_timeout = 1'b1;
`endif
                end
            end
            // pd_req during the ramp aborts without drain: SCCB has no grant yet.
            StPwrWait: begin
                if (pd_req)                          w_state_d = StRstHold;
                else if (r_cnt == T_PWR - 20'd1)     w_state_d = StRstWait;
            end
            StRstWait: begin
                if (pd_req)                          w_state_d = StRstHold;
                else if (r_cnt == T_RST - 20'd1)     w_state_d = StIniWait;
            end
            StIniWait: begin
                if (pd_req)                          w_state_d = StRstHold;
                else if (r_cnt == T_INI - 20'd1)     w_state_d = StOn;
            end
            StOn: begin
                if (pd_req) w_state_d = StDrain;
            end
            StDrain: begin
                if (!sccb_busy) begin
                    w_state_d = StRstHold;
`ifdef CAM_PD_TIMEOUT_EN
                end else if (r_cnt == T_DRAIN - 20'd1) begin
                    w_state_d     = StRstHold;
                    w_set_timeout = 1'b1;
`endif
                end
            end
            StRstHold: begin
                if (r_cnt == T_RST_HOLD - 20'd1) w_state_d = StPwdHold;
            end
            StPwdHold: begin
                if (r_cnt == T_PWD_HOLD - 20'd1) begin
                    w_state_d   = StOff;
                    w_pd_done_d = 1'b1;
                end
            end
            default: w_state_d = StOff;
        endcase
    end

    // Counter restarts on every state entry and saturates rather than wrapping.
    always_comb begin
        w_cnt_d = r_cnt;
        if (w_state_d != r_state) begin
            w_cnt_d = 20'd0;
        end else if (r_state != StOff && r_state != StOn && r_cnt != 20'hfffff) begin
            w_cnt_d = r_cnt + 20'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StOff;
            r_cnt   <= 20'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cam_pwnd   <= 1'b0;
            cam_rst_n  <= 1'b0;
            initial_en <= 1'b0;
            cam_on     <= 1'b0;
            pd_done    <= 1'b0;
        end else begin
            cam_pwnd   <= (w_state_d == StRstWait) || (w_state_d == StIniWait) ||
                          (w_state_d == StOn) || (w_state_d == StDrain) ||
                          (w_state_d == StRstHold);
            cam_rst_n  <= (w_state_d == StIniWait) || (w_state_d == StOn) ||
                          (w_state_d == StDrain);
            initial_en <= (w_state_d == StOn);
            cam_on     <= (w_state_d == StOn);
            pd_done    <= w_pd_done_d;
        end
    end

`ifdef CAM_PD_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pd_timeout <= 1'b0;
        end else if (w_set_timeout) begin
            r_pd_timeout <= 1'b1;
        end else if (w_clr_timeout) begin
            r_pd_timeout <= 1'b0;
        end
    end

    assign pd_timeout = r_pd_timeout;
`endif

endmodule

// File: tb/tb_cam_power_seq.sv
// tb_cam_power_seq: directed spec scenarios followed by randomized requests, each cycle
// compared against a timeline model (mode + elapsed cycles since the mode began).
module tb_cam_power_seq;

    localparam int P_PWR  = 4;
    localparam int P_RST  = 3;
    localparam int P_INI  = 5;
    localparam int P_RH   = 2;
    localparam int P_PH   = 3;
    localparam int P_DR   = 6;
    localparam int P_UP   = P_PWR + P_RST + P_INI;
    localparam int P_DOWN = P_RH + P_PH;
`ifdef CAM_PD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pu_req = 1'b0;
    logic pd_req = 1'b0;
    logic sccb_busy = 1'b0;
    logic cam_pwnd, cam_rst_n, initial_en, cam_on, pd_done;
`ifdef CAM_PD_TIMEOUT_EN
    logic pd_timeout;
`endif

    always #5 clk = ~clk;

    cam_power_seq #(
        .T_PWR      (20'(P_PWR)),
        .T_RST      (20'(P_RST)),
        .T_INI      (20'(P_INI)),
        .T_RST_HOLD (20'(P_RH)),
        .T_PWD_HOLD (20'(P_PH)),
        .T_DRAIN    (20'(P_DR))
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pu_req     (pu_req),
        .pd_req     (pd_req),
        .sccb_busy  (sccb_busy),
        .cam_pwnd   (cam_pwnd),
        .cam_rst_n  (cam_rst_n),
        .initial_en (initial_en),
        .cam_on     (cam_on),
        .pd_done    (pd_done)
`ifdef CAM_PD_TIMEOUT_EN
        ,
        .pd_timeout (pd_timeout)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: 0 off, 1 ramping up, 2 on, 3 draining, 4 powering down.
    int m_mode = 0;
    int m_e    = 0;
    bit m_to   = 1'b0;
    bit m_done = 1'b0;

    task automatic model_step(input bit pu, input bit pd, input bit busy);
        m_done = 1'b0;
        case (m_mode)
            0: if (pu) begin m_mode = 1; m_e = 0; m_to = 1'b0; end
            1: begin
                if (pd) begin
                    m_mode = 4; m_e = 0;
                end else begin
                    m_e++;
                    if (m_e == P_UP) m_mode = 2;
                end
            end
            2: if (pd) begin m_mode = 3; m_e = 0; end
            3: begin
                if (!busy) begin
                    m_mode = 4; m_e = 0;
                end else if (TO_EN && m_e == P_DR - 1) begin
                    m_mode = 4; m_e = 0; m_to = 1'b1;
                end else begin
                    m_e++;
                end
            end
            default: begin
                m_e++;
                if (m_e == P_DOWN) begin m_mode = 0; m_e = 0; m_done = 1'b1; end
            end
        endcase
    endtask

    task automatic check_all();
        bit e_pwnd, e_rst, e_ini, e_on;
        e_pwnd = 1'b0; e_rst = 1'b0; e_ini = 1'b0; e_on = 1'b0;
        case (m_mode)
            1: begin e_pwnd = (m_e >= P_PWR); e_rst = (m_e >= P_PWR + P_RST); end
            2: begin e_pwnd = 1'b1; e_rst = 1'b1; e_ini = 1'b1; e_on = 1'b1; end
            3: begin e_pwnd = 1'b1; e_rst = 1'b1; end
            4: e_pwnd = (m_e < P_RH);
            default: ;
        endcase
        check_eq("cam_pwnd", 32'(cam_pwnd), 32'(e_pwnd));
        check_eq("cam_rst_n", 32'(cam_rst_n), 32'(e_rst));
        check_eq("initial_en", 32'(initial_en), 32'(e_ini));
        check_eq("cam_on", 32'(cam_on), 32'(e_on));
        check_eq("pd_done", 32'(pd_done), 32'(m_done));
`ifdef CAM_PD_TIMEOUT_EN
        check_eq("pd_timeout", 32'(pd_timeout), 32'(m_to));
`endif
    endtask

    task automatic step(input bit pu, input bit pd, input bit busy);
        @(negedge clk);
        pu_req = pu; pd_req = pd; sccb_busy = busy;
        @(posedge clk);
        model_step(pu, pd, busy);
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input bit busy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, busy);
    endtask

    // Reset asserted between clock edges; outputs must drop before any edge arrives.
    task automatic async_reset();
        @(negedge clk);
        pu_req = 1'b0; pd_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        m_mode = 0; m_e = 0; m_to = 1'b0; m_done = 1'b0;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit busy_r;
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 1'b0);

        // Power-up, then power-down with SCCB busy.
        step(1'b1, 1'b0, 1'b0);
        idle(P_UP + 2, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        idle(4, 1'b1);
        idle(P_DOWN + 3, 1'b0);

        // Abort during RST_WAIT.
        step(1'b1, 1'b0, 1'b0);
        idle(P_PWR + 1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(P_DOWN + 2, 1'b0);

        // Collision in ON, pu_req during PWD_HOLD, pd_req in OFF.
        step(1'b1, 1'b0, 1'b0);
        idle(P_UP + 1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(P_RH + 1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        idle(P_PH + 1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(3, 1'b0);

        // Async reset mid INI_WAIT.
        step(1'b1, 1'b0, 1'b0);
        idle(P_PWR + P_RST + 2, 1'b0);
        async_reset();
        idle(4, 1'b0);

        // Stuck-busy drain (times out only with the feature enabled).
        step(1'b1, 1'b0, 1'b0);
        idle(P_UP + 1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        idle(P_DR + P_DOWN + 4, 1'b1);
        idle(2, 1'b0);
        idle(P_DOWN + 2, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        idle(3, 1'b0);

        // Randomized requests with bursty busy.
        busy_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset();
            end else begin
                if ($urandom_range(0, 9) == 0) busy_r = ~busy_r;
                step($urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0, busy_r);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
